// File: rtl/rv_pkg.sv
//------------------------------------------------------------------------------
// Module  : rv_pkg
// Brief   : Shared RISC-V pipeline types and constants for the fetch path.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rv_pkg;

    localparam int          XLEN   = 32;
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
//------------------------------------------------------------------------------
// Module  : if_id_reg
// Brief   : Pipeline payload register with load, flush and hold.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_id_reg
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);

    logic            valid_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_q;

    // Flush only invalidates; the stale payload is never observed while valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= RV_NOP;
            pc_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

`default_nettype wire

// File: rtl/if_fetch_stage.sv
//------------------------------------------------------------------------------
// Module  : if_fetch_stage
// Brief   : PC register, fetch FSM and next-PC mux feeding the IF/ID register.
//           Optional macro FETCH_ALIGN_CHECK_EN traps misaligned redirects.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_fetch_stage
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 32
)
(
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        halted
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_exc
`endif
);

    localparam logic [XLEN-1:0] LAST_PC = XLEN'(MEM_BYTES - 32'd4);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            halted_q, halted_d;
    logic            load, flush;
    logic            adv;
`ifdef FETCH_ALIGN_CHECK_EN
    logic            exc_q, exc_d;
`endif

    assign adv = !id_valid || id_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= WAIT;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            exc_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
`ifdef FETCH_ALIGN_CHECK_EN
            exc_q    <= exc_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        halted_d = halted_q;
        load     = 1'b0;
        flush    = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        exc_d    = exc_q;
`endif
        // Redirect wins over everything, including a capture in the same cycle.
        if (redirect_valid) begin
            flush = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                exc_d    = 1'b1;
                halted_d = 1'b1;
                state_d  = HALT;
            end else
`endif
            begin
                pc_d     = redirect_pc & ~32'h3;
                halted_d = 1'b0;
                state_d  = FETCH;
`ifdef FETCH_ALIGN_CHECK_EN
                exc_d    = 1'b0;
`endif
            end
        end else begin
            case (state_q)
                WAIT:  state_d = FETCH;
                FETCH: begin
                    if (adv) begin
                        if (pc_q <= LAST_PC) begin
                            load = 1'b1;
                            pc_d = pc_q + 32'd4;
                        end else begin
                            flush    = 1'b1;
                            halted_d = 1'b1;
                            state_d  = HALT;
                        end
                    end
                end
                HALT:    state_d = HALT;
                default: state_d = WAIT;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (reset),
        .load_i  (load),
        .flush_i (flush),
        .instr_i (imem_instr),
        .pc_i    (pc_q),
        .valid_o (id_valid),
        .instr_o (id_instr),
        .pc_o    (id_pc)
    );

    assign imem_pc = pc_q;
    assign halted  = halted_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_exc = exc_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
//------------------------------------------------------------------------------
// Module  : tb_if_fetch_stage
// Brief   : Self-checking bench for if_fetch_stage with a behavioural model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_if_fetch_stage;

    localparam int unsigned MEM_BYTES = 32;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_ready = 1'b1;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        halted;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_exc;
`endif

    logic [31:0] mem [0:7];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    initial begin
        mem[0] = 32'h0010_0093; mem[1] = 32'h0020_8093;
        mem[2] = 32'h0030_8093; mem[3] = 32'h0010_8113;
        mem[4] = 32'h0040_0013; mem[5] = 32'h0050_0013;
        mem[6] = 32'h0060_0013; mem[7] = 32'h0070_0013;
    end

    assign imem_instr = (imem_pc < MEM_BYTES) ? mem[imem_pc[4:2]] : 32'hDEAD_BEEF;

    if_fetch_stage #(.RESET_PC(32'h0), .MEM_BYTES(MEM_BYTES)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .halted         (halted)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_exc      (fetch_exc)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Model: mode 0 = settling after reset, 1 = running, 2 = stopped.
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_ipc;
    bit          m_vld, m_halt, m_exc;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_pc = 32'h0; m_vld = 0; m_instr = NOP; m_ipc = 0;
            m_halt = 0; m_exc = 0;
        end else if (redirect_valid) begin
            m_vld = 0;
            if (ALIGN && (redirect_pc % 4 != 0)) begin
                m_exc = 1; m_halt = 1; m_mode = 2;
            end else begin
                m_pc = redirect_pc - (redirect_pc % 4);
                m_exc = 0; m_halt = 0; m_mode = 1;
            end
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1 && (!m_vld || id_ready)) begin
            if (64'(m_pc) + 64'd4 <= 64'(MEM_BYTES)) begin
                m_ipc = m_pc; m_instr = mem[m_pc / 4]; m_vld = 1; m_pc = m_pc + 4;
            end else begin
                m_vld = 0; m_halt = 1; m_mode = 2;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            chk("model id_valid", {31'b0, id_valid}, {31'b0, m_vld});
            chk("model halted", {31'b0, halted}, {31'b0, m_halt});
            chk("model imem_pc", imem_pc, m_pc);
            if (m_vld) begin
                chk("model id_instr", id_instr, m_instr);
                chk("model id_pc", id_pc, m_ipc);
            end
`ifdef FETCH_ALIGN_CHECK_EN
            chk("model fetch_exc", {31'b0, fetch_exc}, {31'b0, m_exc});
`endif
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        step(2);
        chk("reset id_valid", {31'b0, id_valid}, 32'd0);
        chk("reset id_instr", id_instr, NOP);
        chk("reset id_pc", id_pc, 32'd0);
        chk("reset imem_pc", imem_pc, 32'd0);
        chk("reset halted", {31'b0, halted}, 32'd0);
        reset = 1'b0;

        // Streaming after reset: one idle cycle, then back-to-back fetches.
        step();
        chk("t1 wait id_valid", {31'b0, id_valid}, 32'd0);
        step(); chk("t1 pc0", id_pc, 32'd0);  chk("t1 i0", id_instr, 32'h0010_0093);
        step(); chk("t1 pc4", id_pc, 32'd4);  chk("t1 i4", id_instr, 32'h0020_8093);
        step(); chk("t1 pc8", id_pc, 32'd8);  chk("t1 i8", id_instr, 32'h0030_8093);
        step(); chk("t1 pc12", id_pc, 32'd12); chk("t1 i12", id_instr, 32'h0010_8113);

        // Back-pressure while holding pc 4.
        redirect(32'd4);
        step();
        chk("t2 id_pc", id_pc, 32'd4);
        id_ready = 1'b0;
        step(3);
        chk("t2 held instr", id_instr, 32'h0020_8093);
        chk("t2 held id_pc", id_pc, 32'd4);
        chk("t2 held imem_pc", imem_pc, 32'd8);
        id_ready = 1'b1;
        step();
        chk("t2 resume id_pc", id_pc, 32'd8);

        // Redirect overrides a capture of pc 4.
        redirect(32'd4);
        redirect(32'd12);
        chk("t3 flush id_valid", {31'b0, id_valid}, 32'd0);
        step();
        chk("t3 id_pc", id_pc, 32'd12);
        chk("t3 id_instr", id_instr, 32'h0010_8113);

        // Run off the end of memory, then recover.
        step(4);
        chk("t4 last id_pc", id_pc, 32'd28);
        chk("t4 last valid", {31'b0, id_valid}, 32'd1);
        step();
        chk("t4 halted", {31'b0, halted}, 32'd1);
        chk("t4 halt valid", {31'b0, id_valid}, 32'd0);
        step(2);
        chk("t4 halt pc frozen", imem_pc, 32'd32);
        redirect(32'd0);
        chk("t4 unhalted", {31'b0, halted}, 32'd0);
        step();
        chk("t4 refetch", id_instr, 32'h0010_0093);

        // Reset during a stall clears the payload at once.
        id_ready = 1'b0;
        step(2);
        reset = 1'b1;
        #1;
        chk("t5 id_valid", {31'b0, id_valid}, 32'd0);
        chk("t5 id_instr", id_instr, NOP);
        chk("t5 imem_pc", imem_pc, 32'd0);
        step();
        reset = 1'b0;
        id_ready = 1'b1;
        step(2);
        chk("t5 restart id_pc", id_pc, 32'd0);

        // Misaligned redirect target.
        redirect(32'd6);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("t6 exc set", {31'b0, fetch_exc}, 32'd1);
        chk("t6 halted", {31'b0, halted}, 32'd1);
        chk("t6 id_valid", {31'b0, id_valid}, 32'd0);
        step();
        chk("t6 exc sticky", {31'b0, fetch_exc}, 32'd1);
        redirect(32'd8);
        chk("t6 exc clear", {31'b0, fetch_exc}, 32'd0);
        step();
        chk("t6 id_pc", id_pc, 32'd8);
`else
        step();
        chk("t6 id_pc", id_pc, 32'd4);
        chk("t6 id_instr", id_instr, 32'h0020_8093);
`endif
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
